// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl_pkg
// Brief  : Shared widths, defaults and FSM encoding for the data-memory
//          controller and its RAM.
// Rev    : 1.0  initial release
// ============================================================================
package data_mem_ctrl_pkg;

  // Default geometry matching the processor's to_mem port
  localparam int c_data_w = 16;
  localparam int c_addr_w = 16;
  localparam int c_depth  = 4096;
  localparam int c_wait   = 1;

  // Wait counter holds WAIT-1 for WAIT in 0..15
  localparam int c_cnt_w  = 4;

  // Controller states; encodings are shared with external tooling
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAITS  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter preload for a given wait-state count (unused when WAIT is 0)
  function automatic logic [c_cnt_w-1:0] wait_load(input int waits);
    return (waits > 0) ? c_cnt_w'(waits - 1) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_sp_ram.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl_sp_ram
// Brief  : Single-port synchronous RAM, one-cycle read latency, written in
//          the plain style that maps onto block RAM. The array has no reset.
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_ctrl_sp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Enabled port: write the array, or register the addressed word on read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= din;
      end else begin
        dout <= r_mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl
// Brief  : Data-memory controller. Serialises single-word read/write
//          requests from the core against an internal single-port RAM with
//          a fixed number of wait states, returning a one-cycle ack plus
//          read data. Out-of-range addresses complete early with err.
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int ADDR_W = c_addr_w,
  parameter int DEPTH  = c_depth,
  parameter int WAIT   = c_wait
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int                 c_idx_w     = $clog2(DEPTH);
  localparam int                 c_limit_w   = ADDR_W + 1;
  localparam logic [ADDR_W:0]    c_limit     = c_limit_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_wait_load = wait_load(WAIT);

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_wait_cnt;
  logic                r_we;
  logic                r_oor;
  logic [c_idx_w-1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_addr_oor;
  logic                w_ram_en;
  logic [DATA_W-1:0]   w_ram_dout;

  // Range check uses every address bit so high aliases are rejected
  assign w_addr_oor = ({1'b0, addr} >= c_limit);

  // RAM is touched only during the single ACCESS cycle
  assign w_ram_en = (r_state == S_ACCESS);

  data_mem_ctrl_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (c_idx_w)
  ) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (r_we),
    .addr (r_addr),
    .din  (r_wdata),
    .dout (w_ram_dout)
  );

  // Request FSM with wait counter, request latches and registered outputs.
  // ack becomes visible the cycle after RESP, when the state is already
  // IDLE; a req still high during that ack cycle is ignored so a held
  // request cannot issue twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req && !ack) begin
            r_we    <= we;
            r_addr  <= addr[c_idx_w-1:0];
            r_wdata <= wdata;
            r_oor   <= w_addr_oor;
            busy    <= 1'b1;
            if (w_addr_oor) begin
              r_state <= S_RESP;
            end else if (WAIT > 0) begin
              r_wait_cnt <= c_wait_load;
              r_state    <= S_WAITS;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_WAITS: begin
          if (r_wait_cnt == '0) begin
            r_state <= S_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - c_cnt_w'(1);
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          ack  <= 1'b1;
          err  <= r_oor;
          busy <= 1'b0;
          if (!r_we && !r_oor) begin
            rdata <= w_ram_dout;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
